// File: rtl/glyph_rom_arbiter.sv
// rtl/glyph_rom_arbiter.sv - round-robin arbiter sharing one registered glyph ROM; GLYPH_ARB_FIXED_PRI_EN selects fixed lowest-index priority
module glyph_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DIGIT_W = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 12
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DIGIT_W-1:0]  req_digit,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_row,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_col,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [DIGIT_W-1:0]          rom_digit,
  output logic [ADDR_W-1:0]           rom_row,
  output logic [ADDR_W-1:0]           rom_col,
  input  logic [DATA_W-1:0]           rom_data,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0]   ptr_q;
  logic [PTR_W-1:0]   ptr_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic               any_gnt;
  logic [DIGIT_W-1:0] sel_digit;
  logic [ADDR_W-1:0]  sel_row;
  logic [ADDR_W-1:0]  sel_col;
  logic [DIGIT_W-1:0] last_digit_q;
  logic [ADDR_W-1:0]  last_row_q;
  logic [ADDR_W-1:0]  last_col_q;
  logic [NUM_REQ-1:0] tag1_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [DATA_W-1:0]  rsp_data_q;
  int                 idx;

  // Rotating search starting at ptr_q; first asserted request wins and drives the ROM address.
  always_comb begin
    gnt_d     = '0;
    any_gnt   = 1'b0;
    ptr_d     = ptr_q;
    sel_digit = last_digit_q;
    sel_row   = last_row_q;
    sel_col   = last_col_q;
    idx       = 0;
    if (reset_n) begin
      for (int off = 0; off < NUM_REQ; off++) begin
        idx = (int'(ptr_q) + off) % NUM_REQ;
        if (!any_gnt && req[idx]) begin
          any_gnt    = 1'b1;
          gnt_d[idx] = 1'b1;
          sel_digit  = req_digit[idx*DIGIT_W +: DIGIT_W];
          sel_row    = req_row[idx*ADDR_W +: ADDR_W];
          sel_col    = req_col[idx*ADDR_W +: ADDR_W];
          ptr_d      = PTR_W'((idx + 1) % NUM_REQ);
        end
      end
    end
  end

`ifdef GLYPH_ARB_FIXED_PRI_EN
  // Fixed priority: search always starts at index 0.
  assign ptr_q = '0;
`else
  // Priority pointer advances past each winner so every requester gets a turn.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else if (any_gnt) begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // Remember the last granted address so the ROM address is stable while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_digit_q <= '0;
      last_row_q   <= '0;
      last_col_q   <= '0;
    end else if (any_gnt) begin
      last_digit_q <= sel_digit;
      last_row_q   <= sel_row;
      last_col_q   <= sel_col;
    end
  end

  // Two-stage tag pipeline matching the ROM's one-cycle read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag1_q      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '1;
    end else begin
      tag1_q      <= gnt_d;
      rsp_valid_q <= tag1_q;
      if (|tag1_q) begin
        rsp_data_q <= rom_data;
      end
    end
  end

  assign gnt       = gnt_d;
  assign rom_digit = sel_digit;
  assign rom_row   = sel_row;
  assign rom_col   = sel_col;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_glyph_rom_arbiter.sv
// tb/tb_glyph_rom_arbiter.sv - randomized and directed self-checking bench for glyph_rom_arbiter
module tb_glyph_rom_arbiter;

  localparam int NR = 4;
  localparam int DW = 4;
  localparam int AW = 5;
  localparam int XW = 12;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req = '0;
  logic [DW-1:0]     dig [NR] = '{default: '0};
  logic [AW-1:0]     row [NR] = '{default: '0};
  logic [AW-1:0]     col [NR] = '{default: '0};
  logic [NR*DW-1:0]  req_digit;
  logic [NR*AW-1:0]  req_row;
  logic [NR*AW-1:0]  req_col;
  logic [NR-1:0]     gnt;
  logic [DW-1:0]     rom_digit;
  logic [AW-1:0]     rom_row;
  logic [AW-1:0]     rom_col;
  logic [XW-1:0]     rom_data = 12'hFFF;
  logic [NR-1:0]     rsp_valid;
  logic [XW-1:0]     rsp_data;

  int n_chk  = 0;
  int n_fail = 0;

  glyph_rom_arbiter #(.NUM_REQ(NR), .DIGIT_W(DW), .ADDR_W(AW), .DATA_W(XW)) dut (
    .clk(clk), .reset_n(reset_n), .req(req),
    .req_digit(req_digit), .req_row(req_row), .req_col(req_col),
    .gnt(gnt), .rom_digit(rom_digit), .rom_row(rom_row), .rom_col(rom_col),
    .rom_data(rom_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_digit = '0;
    req_row   = '0;
    req_col   = '0;
    for (int i = 0; i < NR; i++) begin
      req_digit[i*DW +: DW] = dig[i];
      req_row[i*AW +: AW]   = row[i];
      req_col[i*AW +: AW]   = col[i];
    end
  end

  function automatic logic [XW-1:0] rom_fn(input logic [DW-1:0] d, input logic [AW-1:0] r,
                                           input logic [AW-1:0] c);
    int s;
    s = int'(r) + int'(c);
    if (d > 4'd9) return 12'hFFF;
    if (s % 3 == 2) return 12'h000;
    if (s % 3 == 0) return 12'hFFF;
    return {d, r[3:0], c[3:0]};
  endfunction

  // Registered-address glyph ROM
  always @(posedge clk) rom_data <= rom_fn(rom_digit, rom_row, rom_col);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int            m_ptr = 0;
  logic [DW-1:0] m_ldig = '0;
  logic [AW-1:0] m_lrow = '0;
  logic [AW-1:0] m_lcol = '0;
  logic [NR-1:0] m_p1v = '0;
  logic [XW-1:0] m_p1d = '0;
  logic [NR-1:0] m_rv = '0;
  logic [XW-1:0] m_rd = 12'hFFF;
  int            s_idx = -1;
  logic [XW-1:0] s_pix = '0;
  logic [DW-1:0] s_dig = '0;
  logic [AW-1:0] s_row = '0;
  logic [AW-1:0] s_col = '0;

  // Model: outputs derived from the arbitration rule and a 2-deep response delay line
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ptr = 0; m_ldig = '0; m_lrow = '0; m_lcol = '0;
      m_p1v = '0; m_rv = '0; m_rd = 12'hFFF;
    end else begin
      m_rv = m_p1v;
      if (m_p1v != 0) m_rd = m_p1d;
      m_p1v = (s_idx >= 0) ? NR'(1 << s_idx) : '0;
      m_p1d = s_pix;
      if (s_idx >= 0) begin
        m_ldig = s_dig; m_lrow = s_row; m_lcol = s_col;
`ifndef GLYPH_ARB_FIXED_PRI_EN
        m_ptr = (s_idx + 1) % NR;
`endif
      end
    end
  end

  // Compare process: every negedge
  always @(negedge clk) begin
    int e;
    e = -1;
    if (reset_n) begin
      for (int off = 0; off < NR; off++) begin
        if (e < 0 && req[(m_ptr + off) % NR]) e = (m_ptr + off) % NR;
      end
    end
    if (e >= 0) begin
      s_dig = dig[e]; s_row = row[e]; s_col = col[e];
    end else begin
      s_dig = m_ldig; s_row = m_lrow; s_col = m_lcol;
    end
    s_idx = e;
    s_pix = rom_fn(s_dig, s_row, s_col);
    chk("m_gnt", gnt, (e >= 0) ? (32'd1 << e) : 32'd0);
    chk("m_rom_digit", rom_digit, s_dig);
    chk("m_rom_row", rom_row, s_row);
    chk("m_rom_col", rom_col, s_col);
    chk("m_rsp_valid", rsp_valid, m_rv);
    chk("m_rsp_data", rsp_data, m_rd);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  logic [NR-1:0] g_seq [7];
  logic [NR-1:0] v_seq [7];
  logic [NR-1:0] exp_g [5];

  initial begin
    // Reset with all requests asserted
    reset_n = 1'b0; req = 4'hF;
    cyc(); cyc();
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 12'hFFF);
    chk("rst_rom_row", rom_row, 0);
    chk("rst_rom_col", rom_col, 0);
    cyc(); reset_n = 1'b1; req = '0;

    // Single fetch
    cyc();
    req = 4'b0010; dig[1] = 4'd2; row[1] = 5'd1; col[1] = 5'd10;
    @(negedge clk);
    chk("single_gnt", gnt, 4'b0010);
    chk("single_row", rom_row, 1);
    chk("single_col", rom_col, 10);
    cyc(); req = '0;
    cyc();
    @(negedge clk);
    chk("single_rsp_valid", rsp_valid, 4'b0010);
    chk("single_rsp_data", rsp_data, 12'h000);
    req = 4'b0010; row[1] = 5'd0; col[1] = 5'd0;
    @(negedge clk);
    chk("single2_gnt", gnt, 4'b0010);
    cyc(); req = '0;
    cyc();
    @(negedge clk);
    chk("single2_rsp_valid", rsp_valid, 4'b0010);
    chk("single2_rsp_data", rsp_data, 12'hFFF);

    // Full contention from reset
    cyc(); reset_n = 1'b0;
    cyc(); reset_n = 1'b1; req = 4'hF;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      g_seq[i] = gnt; v_seq[i] = rsp_valid;
      cyc();
      if (i == 4) req = '0;
    end
`ifdef GLYPH_ARB_FIXED_PRI_EN
    exp_g = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("contend_gnt%0d", i), g_seq[i], exp_g[i]);
      chk($sformatf("contend_rsp%0d", i + 2), v_seq[i + 2], exp_g[i]);
    end
    chk("contend_rsp0", v_seq[0], 0);
    chk("contend_rsp1", v_seq[1], 0);

    // Pointer skip
    req = 4'b0100;
    @(negedge clk); chk("skip_gnt0", gnt, 4'b0100);
    cyc(); req = 4'b0101;
    @(negedge clk); chk("skip_gnt1", gnt, 4'b0001);
    cyc();
`ifdef GLYPH_ARB_FIXED_PRI_EN
    @(negedge clk); chk("skip_gnt2", gnt, 4'b0001);
`else
    @(negedge clk); chk("skip_gnt2", gnt, 4'b0100);
`endif
    cyc(); req = '0;
    cyc(); cyc();

    // Reset mid-flight
    req = 4'hF;
    @(negedge clk);
    cyc(); reset_n = 1'b0; req = '0;
    cyc();
    cyc(); reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_rsp%0d", i), rsp_valid, 0);
      cyc();
    end
    req = 4'hF;
    @(negedge clk); chk("midrst_gnt", gnt, 4'b0001);
    cyc(); req = '0;

    // Randomized phase, checked by the model
    for (int n = 0; n < 400; n++) begin
      cyc();
      reset_n = ($urandom_range(0, 60) != 0);
      req = ($urandom_range(0, 7) == 0) ? 4'hF : NR'($urandom_range(0, 15));
      for (int i = 0; i < NR; i++) begin
        dig[i] = DW'($urandom_range(0, 15));
        row[i] = AW'($urandom_range(0, 31));
        col[i] = AW'($urandom_range(0, 31));
      end
    end
    cyc(); reset_n = 1'b1; req = '0;
    cyc(); cyc(); cyc();
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/glyph_rom_arbiter.md
# glyph_rom_arbiter

Shares one registered-address glyph ROM (32x32 sprite, 12-bit RGB444 pixel, 5-bit row/col) among several on-screen requesters, e.g. score digits, timer digits, lives counter. It sits between the per-object pixel generators and the glyph ROM / digit-select mux. It grants at most one request per cycle round-robin, drives the ROM address, and returns the fetched pixel to the granted requester with a one-hot valid tag.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DIGIT_W, 4, glyph-select width
- ADDR_W, 5, row and column width each
- DATA_W, 12, pixel colour width

Ports:
- clk  in  1  system/pixel clock
- reset_n  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level
- req_digit  in  NUM_REQ*DIGIT_W  glyph select; requester i at slice [i*DIGIT_W +: DIGIT_W]
- req_row  in  NUM_REQ*ADDR_W  glyph row, packed the same way
- req_col  in  NUM_REQ*ADDR_W  glyph column, packed the same way
- gnt  out  NUM_REQ  one-hot grant, same cycle as acceptance
- rom_digit  out  DIGIT_W  glyph select to ROM mux
- rom_row  out  ADDR_W  row to ROM
- rom_col  out  ADDR_W  column to ROM
- rom_data  in  DATA_W  ROM pixel; valid the cycle after the address is presented
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered
- rsp_data  out  DATA_W  returned pixel, registered

## Operation
- Arbitration is combinational from req and the priority pointer ptr (clog2(NUM_REQ) bits). Search starts at index ptr and wraps. The first asserted req wins, and its gnt bit is set.
- On any grant to index k, ptr is updated to (k+1) mod NUM_REQ at the clock edge. With no grant, ptr holds its value.
- rom_digit/rom_row/rom_col are a combinational mux of the granted slice. With no grant, they hold the last granted values from a registered copy, so the ROM address does not toggle when idle.
- Stage-1 register tag1 is set to gnt every cycle.
- Stage-2 registers, every cycle: rsp_valid <= tag1 and rsp_data <= rom_data when tag1 != 0. Otherwise rsp_data holds its value.
- Requesters may hold req high across cycles. Each cycle with gnt[i]=1 counts as a separate accepted fetch.
- The block passes glyph codes through unchecked. An out-of-range digit returns whatever the ROM mux defaults to (white, 12'hFFF).

## Timing
- Request accepted in cycle t, with gnt asserted in t and the ROM address driven in t.
- ROM captures the address at the end of t, and rom_data is valid in t+1.
- rsp_valid and rsp_data are valid in t+2. Fixed latency is 2, and throughput is 1 fetch per cycle.
- Reset values:
  - gnt = 0, forced low while reset_n = 0
  - rsp_valid = 0
  - rsp_data = 12'hFFF
  - rom_digit/row/col = 0
  - ptr = 0
  - tag1 = 0
- Reset mid-operation clears tag1 and rsp_valid. In-flight fetches are dropped, and no rsp_valid appears after reset_n rises for grants issued before reset.
- Simultaneous requests: exactly one gnt bit per cycle. Unserved requesters must keep req asserted.
- Wrap-around: a grant at index NUM_REQ-1 sets ptr = 0.

## Configuration
- GLYPH_ARB_FIXED_PRI_EN defined:
  - Fixed priority, lowest index wins.
  - ptr is removed, or tied to 0 and never updated.
- GLYPH_ARB_FIXED_PRI_EN undefined:
  - Round-robin as described above (default build).

## Test plan
- Reset: hold reset_n=0 with req=4'b1111 -> gnt=0, rsp_valid=0, rsp_data=12'hFFF, rom_row=rom_col=0.
- Single fetch:
  - Stimulus: req=4'b0010, requester 1 digit=2, row=1, col=10 in cycle t.
  - Required: gnt=4'b0010 and rom_row=1, rom_col=10 in t.
  - Required: rsp_valid=4'b0010 and rsp_data=12'h000 in t+2.
  - Then row=0, col=0 -> rsp_data=12'hFFF.
- Full contention: req=4'b1111 held for 5 cycles from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001, with the rsp_valid sequence identical, delayed 2 cycles.
- Pointer skip: after a grant to index 2, req=4'b0101 -> gnt=0100 is skipped since ptr=3, giving gnt=0001, then 0100.
- Reset mid-flight: grant in cycle t, reset_n low in t+1, release in t+3 -> rsp_valid stays 0 and the next grant with req=4'b1111 goes to index 0.
- With GLYPH_ARB_FIXED_PRI_EN: req=4'b1111 held -> gnt=0001 every cycle, rsp_valid=0001 every cycle from the third.
